fp_decoder_serial: RTL and testbench
====================================

Name: fp_decoder_serial

Overview:
- Converts a compressed floating-point word (sign, 3-bit exponent, 4-bit significand) back to a 12-bit two's-complement linear value.
- This is the inverse of the linear-to-float conversion and rounding path.
- Sits on the playback/readback side of the fpcvt datapath, between the float storage/transport stage and linear consumers.
- Uses a serial shifter, so latency depends on the exponent. Valid/ready handshakes are used on both sides.

Parameters:
- EXP_W, 3, exponent width; shift count range is 0..2^EXP_W-1.
- SIG_W, 4, significand width.
- OUT_W, 12, output width. Must satisfy OUT_W >= SIG_W + 2^EXP_W; default is exactly the minimum.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept an input word.
- in_sign  input  1  1 = negative.
- in_exp  input  EXP_W  left-shift amount.
- in_sig  input  SIG_W  unsigned significand magnitude.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  OUT_W  two's-complement result = (sign ? -1 : 1) * (sig << exp).

Behaviour:
- Reset (asynchronous on rst_n low, released synchronously by design convention): state=IDLE, in_ready=1, out_valid=0, out_data=0, internal acc=0, cnt=0, sign_q=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture: acc = zero-extended in_sig (OUT_W bits), cnt = in_exp, sign_q = in_sign; then go to SHIFT.
- SHIFT:
  - in_ready=0.
  - If cnt != 0: acc <<= 1, cnt -= 1.
  - If cnt == 0: out_data = sign_q ? (~acc + 1) : acc (OUT_W-bit wrap arithmetic), out_valid=1, go to DONE.
- DONE:
  - out_valid=1 and out_data held stable until out_ready.
  - On out_valid && out_ready: out_valid=0, go to IDLE.
  - in_ready stays 0 during the handoff cycle. There is no same-cycle accept on output completion; the next input is accepted at the earliest in the following cycle.
- Latency: out_valid rises exp+1 clocks after the accepting edge (exp=0 -> 1 clock, exp=7 -> 8 clocks).
- Throughput: one word per exp+3 clocks minimum with out_ready held high.
- Arithmetic:
  - acc never overflows OUT_W, since the max magnitude is (2^SIG_W-1)<<(2^EXP_W-1) = 1920 < 2048.
  - Negation of 1920 is exact (0x880).
  - sign=1 with sig=0 yields 0 (no negative zero).
- No normalization requirement on in_sig; any 0..15 value is decoded literally.
- in_* are sampled only on the accept edge; changes to them at other times are ignored.
- out_ready while out_valid=0 is ignored.
- Reset asserted mid-SHIFT or mid-DONE: the in-flight word is discarded and outputs return to reset values immediately (asynchronous).

Optional Feature:
- FP_DECODER_FAST_EN defined:
  - SHIFT state performs the full shift (acc << cnt, barrel shifter) and the sign application in one cycle.
  - out_valid rises exactly 1 clock after accept for every exponent.
  - Results are bit-identical to the serial mode.
- Undefined: serial one-bit-per-cycle shifter as described above (smaller area).
- Both builds must pass the same test plan, with latency checks parameterized on the macro.

Test Plan:
- Reset then sign=0, exp=3, sig=0xB, out_ready=1 -> out_data=0x058 (88); out_valid asserted 4 clocks after accept (1 clock if FAST), high for exactly 1 cycle; in_ready returns to 1 the cycle after.
- sign=1, exp=7, sig=0xF -> out_data=0x880 (-1920) after 8 clocks.
- sign=0, exp=0, sig=0x5 -> out_data=0x005 after 1 clock.
- sign=1, exp=2, sig=0x0 -> out_data=0x000.
- Backpressure: exp=1, sig=0x9, sign=1; hold out_ready=0 for 5 cycles -> out_data stays 0xFEE (-18) and in_ready stays 0; a new in_valid during this window is not accepted. Raise out_ready -> handshake completes, and the pending input is accepted the cycle after.
- Reset mid-operation: accept exp=6, sig=0x7; pull rst_n low 3 clocks later (asynchronous, between edges) -> out_valid=0, out_data=0, in_ready=1 immediately. After release, a fresh word (sign=0, exp=1, sig=0x3) decodes to 0x006 with no residue from the aborted word.

Source files
------------

// File: rtl/fp_decoder_serial.sv
// Decodes a sign/exponent/significand float word into an OUT_W-bit two's-complement value.
// Optional macro FP_DECODER_FAST_EN replaces the one-bit-per-cycle shifter with a single-cycle barrel shift.
module fp_decoder_serial #(
    parameter int EXP_W = 3,
    parameter int SIG_W = 4,
    parameter int OUT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [SIG_W-1:0] in_sig,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [OUT_W-1:0] r_acc;
    logic [OUT_W-1:0] w_acc_nxt;
    logic [EXP_W-1:0] r_cnt;
    logic [EXP_W-1:0] w_cnt_nxt;
    logic             r_sign;
    logic             w_sign_nxt;
    logic             r_in_ready;
    logic             w_in_ready_nxt;
    logic             r_out_valid;
    logic             w_out_valid_nxt;
    logic [OUT_W-1:0] r_out_data;
    logic [OUT_W-1:0] w_out_data_nxt;

    // Wrap-around negation; a zero magnitude stays zero, so there is no negative zero.
    function automatic logic [OUT_W-1:0] apply_sign(input logic neg, input logic [OUT_W-1:0] mag);
        logic [OUT_W-1:0] res;
        if (neg) begin
            res = ~mag + OUT_W'(1);
        end else begin
            res = mag;
        end
        return res;
    endfunction

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sign      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sign      <= w_sign_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_cnt_nxt       = r_cnt;
        w_sign_nxt      = r_sign;
        w_in_ready_nxt  = r_in_ready;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_acc_nxt      = {{(OUT_W-SIG_W){1'b0}}, in_sig};
                    w_cnt_nxt      = in_exp;
                    w_sign_nxt     = in_sign;
                    w_in_ready_nxt = 1'b0;
                    w_state_nxt    = SHIFT;
                end else begin
                    w_in_ready_nxt = 1'b1;
                end
            end
            SHIFT: begin
`ifdef FP_DECODER_FAST_EN
                w_acc_nxt       = r_acc << r_cnt;
                w_cnt_nxt       = '0;
                w_out_data_nxt  = apply_sign(r_sign, r_acc << r_cnt);
                w_out_valid_nxt = 1'b1;
                w_state_nxt     = DONE;
`else
                if (r_cnt != '0) begin
                    w_acc_nxt = {r_acc[OUT_W-2:0], 1'b0};
                    w_cnt_nxt = r_cnt - EXP_W'(1);
                end else begin
                    w_out_data_nxt  = apply_sign(r_sign, r_acc);
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = DONE;
                end
`endif
            end
            DONE: begin
                // in_ready only rises after the handoff edge: no same-cycle re-accept.
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_in_ready_nxt  = 1'b1;
                    w_state_nxt     = IDLE;
                end else begin
                    w_out_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_in_ready_nxt  = 1'b1;
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_fp_decoder_serial.sv
// Self-checking bench for fp_decoder_serial: directed, random, backpressure and mid-flight reset.
// Latency expectations follow FP_DECODER_FAST_EN when it is defined.
module tb_fp_decoder_serial;

`ifdef FP_DECODER_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [2:0]  in_exp;
    logic [3:0]  in_sig;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;

    int n_vec;
    int n_err;

    fp_decoder_serial #(.EXP_W(3), .SIG_W(4), .OUT_W(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_sig    (in_sig),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: signed value sig * 2^exp, wrapped to 12 bits.
    function automatic logic [11:0] ref_decode(input logic s, input int e, input int g);
        int mag;
        int v;
        mag = g * (2 ** e);
        v   = s ? -mag : mag;
        return v[11:0];
    endfunction

    function automatic int exp_lat(input int e);
        if (FAST) return 1;
        else return e + 1;
    endfunction

    task automatic scramble_inputs();
        logic [31:0] r;
        r = $urandom;
        in_sign = r[0];
        in_exp  = r[3:1];
        in_sig  = r[7:4];
    endtask

    // Drives one word with out_ready high and reports what the DUT did.
    task automatic run_word(input logic s, input logic [2:0] e, input logic [3:0] g,
                            output int lat, output logic [11:0] data, output logic rdy_at_valid,
                            output logic valid_after, output logic rdy_after);
        @(negedge clk);
        in_valid = 1'b1; in_sign = s; in_exp = e; in_sig = g;
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble_inputs();
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); lat++; #1;
        end
        data         = out_data;
        rdy_at_valid = in_ready;
        @(posedge clk); #1;
        valid_after = out_valid;
        rdy_after   = in_ready;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_vec++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_vec++; if (out_data !== 12'h000) begin n_err++; $display("FAIL reset_out_data got %h want 000", out_data); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic        ss [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  ee [4] = '{3'd3, 3'd7, 3'd0, 3'd2};
        logic [3:0]  gg [4] = '{4'hB, 4'hF, 4'h5, 4'h0};
        logic [11:0] want [4] = '{12'h058, 12'h880, 12'h005, 12'h000};
        int lat; logic [11:0] d; logic rv, va, ra;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_word(ss[i], ee[i], gg[i], lat, d, rv, va, ra);
            n_vec++; if (d !== want[i]) begin n_err++; $display("FAIL dir%0d_data got %h want %h", i, d, want[i]); end
            n_vec++; if (d !== ref_decode(ss[i], ee[i], gg[i])) begin n_err++; $display("FAIL dir%0d_model got %h want %h", i, d, ref_decode(ss[i], ee[i], gg[i])); end
            n_vec++; if (lat !== exp_lat(ee[i])) begin n_err++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, exp_lat(ee[i])); end
            n_vec++; if (rv !== 1'b0) begin n_err++; $display("FAIL dir%0d_ready_in_done got %b want 0", i, rv); end
            n_vec++; if (va !== 1'b0) begin n_err++; $display("FAIL dir%0d_valid_one_cycle got %b want 0", i, va); end
            n_vec++; if (ra !== 1'b1) begin n_err++; $display("FAIL dir%0d_ready_return got %b want 1", i, ra); end
        end
    endtask

    task automatic test_random();
        int lat; logic [11:0] d; logic rv, va, ra;
        logic [31:0] r;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            run_word(r[0], r[3:1], r[7:4], lat, d, rv, va, ra);
            n_vec++; if (d !== ref_decode(r[0], int'(r[3:1]), int'(r[7:4]))) begin
                n_err++; $display("FAIL rnd%0d_data s=%b e=%0d g=%0d got %h want %h", i, r[0], r[3:1], r[7:4], d, ref_decode(r[0], int'(r[3:1]), int'(r[7:4])));
            end
            n_vec++; if (lat !== exp_lat(int'(r[3:1]))) begin n_err++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, exp_lat(int'(r[3:1]))); end
            n_vec++; if (ra !== 1'b1 || va !== 1'b0) begin n_err++; $display("FAIL rnd%0d_handoff got valid=%b ready=%b want 0/1", i, va, ra); end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [11:0] want;
        out_ready = 1'b0;
        want = ref_decode(1'b1, 1, 9);
        @(negedge clk);
        in_valid = 1'b1; in_sign = 1'b1; in_exp = 3'd1; in_sig = 4'h9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); lat++; #1; end
        n_vec++; if (lat !== exp_lat(1)) begin n_err++; $display("FAIL bp_latency got %0d want %0d", lat, exp_lat(1)); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) begin in_valid = 1'b1; in_sign = 1'b0; in_exp = 3'd2; in_sig = 4'h3; end
            n_vec++; if (out_data !== 12'hFEE || out_data !== want) begin n_err++; $display("FAIL bp_hold%0d_data got %h want fee", c, out_data); end
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold%0d_valid got %b want 1", c, out_valid); end
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold%0d_in_ready got %b want 0", c, in_ready); end
            @(posedge clk);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_handoff_valid got %b want 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_handoff_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_pending_accept got %b want 0", in_ready); end
        in_valid = 1'b0;
        scramble_inputs();
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); lat++; #1; end
        n_vec++; if (out_data !== ref_decode(1'b0, 2, 3)) begin n_err++; $display("FAIL bp_pending_data got %h want %h", out_data, ref_decode(1'b0, 2, 3)); end
        n_vec++; if (lat !== exp_lat(2)) begin n_err++; $display("FAIL bp_pending_latency got %0d want %0d", lat, exp_lat(2)); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat; logic [11:0] d; logic rv, va, ra;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_sign = 1'b1; in_exp = 3'd6; in_sig = 4'h7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
        n_vec++; if (out_data !== 12'h000) begin n_err++; $display("FAIL rstmid_data got %h want 000", out_data); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got %b want 1", in_ready); end
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        run_word(1'b0, 3'd1, 4'h3, lat, d, rv, va, ra);
        n_vec++; if (d !== 12'h006) begin n_err++; $display("FAIL rstmid_fresh_data got %h want 006", d); end
        n_vec++; if (lat !== exp_lat(1)) begin n_err++; $display("FAIL rstmid_fresh_latency got %0d want %0d", lat, exp_lat(1)); end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        in_valid = 1'b0; in_sign = 1'b0; in_exp = 3'd0; in_sig = 4'h0;
        out_ready = 1'b1; rst_n = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
